// File: rtl/cpu_mem_loader.sv
// -----------------------------------------------------------------------------
// cpu_mem_loader
//
// Host-side loader that sits directly upstream of the cpu core. It consumes a
// 32-bit command/payload stream over a valid/ready handshake. It writes 32-bit
// instruction words into instruction memory and 64-bit data words into data
// memory through the core's external memory ports. It also drives the core's
// enable input.
//
// Stream format: a header word {cmd[31:30], reserved[29:16], n[15:0]}.
//   cmd 00 LOAD_IMEM, 01 LOAD_DMEM, 10 START, 11 STOP.
// A LOAD header is followed by a base byte address word and then the payload.
// An IMEM payload is n words. A DMEM payload is n lo/hi word pairs.
//
// Optional feature: define CPU_MEM_LOADER_CHECKSUM_EN to require a trailer
// word after every load. The trailer is the mod-2^32 sum of the payload words.
// A trailer mismatch sets the sticky err flag, and START is then ignored until
// the next LOAD. Without the macro, err is tied to 0.
//
// Ports:
//   clk, arst_n                    clock, asynchronous active-low reset
//   in_data/in_valid/in_ready      command/payload stream
//   addr_ext/wen_ext/ren_ext/wdata_ext          instruction memory port
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2  data memory port
//   cpu_enable                     drives cpu.enable
//   busy                           loader is not idle
//   done                           one-cycle pulse when a load completes
//   err                            sticky checksum error
// -----------------------------------------------------------------------------
module cpu_mem_loader #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // The depths only describe the attached SRAMs. Out-of-range addresses wrap
  // inside the SRAM's own decoder, so the loader does no bounds checking.
  if (IMEM_WORDS < 1 || DMEM_WORDS < 1) begin : g_bad_depth
    $error("cpu_mem_loader: memory depths must be positive");
  end

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_BASE      = 3'd1;
  localparam logic [2:0] S_IMEM_DATA = 3'd2;
  localparam logic [2:0] S_DMEM_LO   = 3'd3;
  localparam logic [2:0] S_DMEM_HI   = 3'd4;
`ifdef CPU_MEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK     = 3'd5;
`endif

  localparam logic [1:0] CMD_LOAD_IMEM = 2'b00;
  localparam logic [1:0] CMD_LOAD_DMEM = 2'b01;
  localparam logic [1:0] CMD_START     = 2'b10;

  logic [2:0]  state_q, state_d;
  logic        is_dmem_q, is_dmem_d;
  logic [15:0] cnt_q, cnt_d;          // remaining target words
  logic [63:0] addr_q, addr_d;        // address of the next write
  logic [31:0] lo_q, lo_d;            // low half of the DMEM word in flight
  logic        ready_q;
  logic [63:0] addr_ext_q, addr_ext_d;
  logic [31:0] wdata_ext_q, wdata_ext_d;
  logic        wen_ext_q, wen_ext_d;
  logic [63:0] addr_ext_2_q, addr_ext_2_d;
  logic [63:0] wdata_ext_2_q, wdata_ext_2_d;
  logic        wen_ext_2_q, wen_ext_2_d;
  logic        enable_q, enable_d;
  logic        done_q, done_d;

  logic        accept;
  logic        load_end;
  logic        err_flag;
  logic [1:0]  hdr_cmd;

`ifdef CPU_MEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        err_q, err_d;
  assign err_flag = err_q;
`else
  assign err_flag = 1'b0;
`endif

  assign accept  = in_valid & ready_q;
  assign hdr_cmd = in_data[31:30];

  always_comb begin
    // NOTE: every signal assigned here first takes a default (hold or idle).
    // Any path that leaves one unassigned would otherwise infer a latch.
    state_d       = state_q;
    is_dmem_d     = is_dmem_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    lo_d          = lo_q;
    addr_ext_d    = addr_ext_q;
    wdata_ext_d   = wdata_ext_q;
    wen_ext_d     = 1'b0;
    addr_ext_2_d  = addr_ext_2_q;
    wdata_ext_2_d = wdata_ext_2_q;
    wen_ext_2_d   = 1'b0;
    enable_d      = enable_q;
    done_d        = 1'b0;
    load_end      = 1'b0;
`ifdef CPU_MEM_LOADER_CHECKSUM_EN
    sum_d         = sum_q;
    err_d         = err_q;
`endif

    if (accept) begin
      case (state_q)
        S_IDLE: begin
          case (hdr_cmd)
            CMD_LOAD_IMEM, CMD_LOAD_DMEM: begin
              enable_d  = 1'b0;
              is_dmem_d = hdr_cmd[0];
              cnt_d     = in_data[15:0];
              state_d   = S_BASE;
`ifdef CPU_MEM_LOADER_CHECKSUM_EN
              err_d     = 1'b0;
              sum_d     = 32'h0;
`endif
            end
            CMD_START: if (!err_flag) enable_d = 1'b1;
            default:   enable_d = 1'b0;  // STOP
          endcase
        end

        S_BASE: begin
          // Base is zero-extended, with the alignment bits forced to zero.
          addr_d = is_dmem_q ? {32'h0, in_data[31:3], 3'b000}
                             : {32'h0, in_data[31:2], 2'b00};
          if (cnt_q == 16'd0) load_end = 1'b1;
          else if (is_dmem_q) state_d = S_DMEM_LO;
          else                state_d = S_IMEM_DATA;
        end

        S_IMEM_DATA: begin
          addr_ext_d  = addr_q;
          wdata_ext_d = in_data;
          wen_ext_d   = 1'b1;
          addr_d      = addr_q + 64'd4;
          cnt_d       = cnt_q - 16'd1;
`ifdef CPU_MEM_LOADER_CHECKSUM_EN
          sum_d       = sum_q + in_data;
`endif
          if (cnt_q == 16'd1) load_end = 1'b1;
        end

        S_DMEM_LO: begin
          lo_d    = in_data;
          state_d = S_DMEM_HI;
`ifdef CPU_MEM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
        end

        S_DMEM_HI: begin
          addr_ext_2_d  = addr_q;
          wdata_ext_2_d = {in_data, lo_q};
          wen_ext_2_d   = 1'b1;
          addr_d        = addr_q + 64'd8;
          cnt_d         = cnt_q - 16'd1;
`ifdef CPU_MEM_LOADER_CHECKSUM_EN
          sum_d         = sum_q + in_data;
`endif
          if (cnt_q == 16'd1) load_end = 1'b1;
          else                state_d  = S_DMEM_LO;
        end

`ifdef CPU_MEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          err_d   = (in_data != sum_q);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
`endif

        default: state_d = S_IDLE;
      endcase

      // The end of the payload either completes the load or collects the
      // trailer first.
      if (load_end) begin
`ifdef CPU_MEM_LOADER_CHECKSUM_EN
        state_d = S_CHECK;
`else
        state_d = S_IDLE;
        done_d  = 1'b1;
`endif
      end
    end
  end

  // ready_q is cleared by reset and set by the first clock after release.
  // This holds in_ready low for exactly one cycle after arst_n rises.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= S_IDLE;
      is_dmem_q     <= 1'b0;
      cnt_q         <= 16'h0;
      addr_q        <= 64'h0;
      lo_q          <= 32'h0;
      ready_q       <= 1'b0;
      addr_ext_q    <= 64'h0;
      wdata_ext_q   <= 32'h0;
      wen_ext_q     <= 1'b0;
      addr_ext_2_q  <= 64'h0;
      wdata_ext_2_q <= 64'h0;
      wen_ext_2_q   <= 1'b0;
      enable_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments, so every flop
      // samples the values from before this edge regardless of order.
      state_q       <= state_d;
      is_dmem_q     <= is_dmem_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      lo_q          <= lo_d;
      ready_q       <= 1'b1;
      addr_ext_q    <= addr_ext_d;
      wdata_ext_q   <= wdata_ext_d;
      wen_ext_q     <= wen_ext_d;
      addr_ext_2_q  <= addr_ext_2_d;
      wdata_ext_2_q <= wdata_ext_2_d;
      wen_ext_2_q   <= wen_ext_2_d;
      enable_q      <= enable_d;
      done_q        <= done_d;
    end
  end

`ifdef CPU_MEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sum_q <= 32'h0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end
`endif

  assign in_ready    = ready_q;
  assign addr_ext    = addr_ext_q;
  assign wen_ext     = wen_ext_q;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata_ext_q;
  assign addr_ext_2  = addr_ext_2_q;
  assign wen_ext_2   = wen_ext_2_q;
  assign ren_ext_2   = 1'b0;
  assign wdata_ext_2 = wdata_ext_2_q;
  assign cpu_enable  = enable_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_flag;

endmodule

// File: tb/tb_cpu_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_cpu_mem_loader
//
// Directed bench for cpu_mem_loader. The stream driver knows the packet it
// sends, so on each accepting edge it records the write, done pulse and
// run-control state that must follow. A compare process checks every DUT
// output against that record on every falling edge. Literal checks after each
// scenario pin the model to hand-computed addresses and data.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_mem_loader;

`ifdef CPU_MEM_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk;
  logic        arst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic        cpu_enable;
  logic        busy;
  logic        done;
  logic        err;

  cpu_mem_loader #(.IMEM_WORDS(512), .DMEM_WORDS(1024)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .cpu_enable  (cpu_enable),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         q_i[$];
  wr_t         q_d[$];
  int          q_done[$];
  logic [63:0] log_i_addr[$], log_i_data[$], log_d_addr[$], log_d_data[$];
  int          done_cnt;

  int          errors;
  int          checks;
  int          cyc;
  int          hdr_cyc, last_cyc;
  logic        en_after_hdr;

  logic        exp_en, exp_busy, exp_ready, exp_err;
  logic [63:0] hold_ia, hold_id, hold_da, hold_dd;
  logic [31:0] pay [8];

  initial begin
    cyc = 0;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (q_i.size() > 0 && q_i[0].cyc == cyc) begin
      check("imem_wen", 64'(wen_ext), 64'd1);
      check("imem_addr", addr_ext, q_i[0].addr);
      check("imem_data", 64'(wdata_ext), q_i[0].data);
      hold_ia = q_i[0].addr;
      hold_id = q_i[0].data;
      void'(q_i.pop_front());
    end else begin
      check("imem_wen", 64'(wen_ext), 64'd0);
      check("imem_addr_hold", addr_ext, hold_ia);
      check("imem_data_hold", 64'(wdata_ext), hold_id);
    end
    if (wen_ext) begin
      log_i_addr.push_back(addr_ext);
      log_i_data.push_back(64'(wdata_ext));
    end

    if (q_d.size() > 0 && q_d[0].cyc == cyc) begin
      check("dmem_wen", 64'(wen_ext_2), 64'd1);
      check("dmem_addr", addr_ext_2, q_d[0].addr);
      check("dmem_data", wdata_ext_2, q_d[0].data);
      hold_da = q_d[0].addr;
      hold_dd = q_d[0].data;
      void'(q_d.pop_front());
    end else begin
      check("dmem_wen", 64'(wen_ext_2), 64'd0);
      check("dmem_addr_hold", addr_ext_2, hold_da);
      check("dmem_data_hold", wdata_ext_2, hold_dd);
    end
    if (wen_ext_2) begin
      log_d_addr.push_back(addr_ext_2);
      log_d_data.push_back(wdata_ext_2);
    end

    if (q_done.size() > 0 && q_done[0] == cyc) begin
      check("done", 64'(done), 64'd1);
      void'(q_done.pop_front());
    end else begin
      check("done", 64'(done), 64'd0);
    end
    if (done) done_cnt++;

    check("cpu_enable", 64'(cpu_enable), 64'(exp_en));
    check("busy", 64'(busy), 64'(exp_busy));
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("err", 64'(err), 64'(exp_err));
    check("ren_ext", 64'(ren_ext), 64'd0);
    check("ren_ext_2", 64'(ren_ext_2), 64'd0);
  end

  // Present one word and wait (bounded) for the edge that accepts it. On
  // return the time is just after that edge, so cyc names the accepting edge.
  task automatic send_word(input logic [31:0] w, input int gap);
    bit acc;
    int budget;
    acc = 1'b0;
    budget = 0;
    in_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    while (!acc && budget < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  // Send one LOAD packet. nsend < n leaves the load unfinished.
  task automatic load(input logic dmem, input int n, input logic [31:0] base,
                      input int nsend, input int gap, input logic corrupt,
                      input logic [13:0] rsv);
    logic [63:0] a;
    logic [31:0] sum;
    wr_t         w;
    send_word({1'b0, dmem, rsv, n[15:0]}, 0);
    hdr_cyc      = cyc;
    en_after_hdr = cpu_enable;
    exp_en       = 1'b0;
    exp_busy     = 1'b1;
    exp_err      = 1'b0;
    send_word(base, gap);
    a   = dmem ? {32'h0, base & 32'hFFFF_FFF8} : {32'h0, base & 32'hFFFF_FFFC};
    sum = 32'h0;
    for (int i = 0; i < nsend; i++) begin
      if (dmem) begin
        send_word(pay[2*i], gap);
        send_word(pay[2*i+1], gap);
        w.cyc  = cyc;
        w.addr = a + 64'(8 * i);
        w.data = {pay[2*i+1], pay[2*i]};
        q_d.push_back(w);
        sum = sum + pay[2*i] + pay[2*i+1];
      end else begin
        send_word(pay[i], gap);
        w.cyc  = cyc;
        w.addr = a + 64'(4 * i);
        w.data = {32'h0, pay[i]};
        q_i.push_back(w);
        sum = sum + pay[i];
      end
    end
    last_cyc = cyc;
    if (nsend == n) begin
      if (CK_EN) send_word(sum + {31'h0, corrupt}, gap);
      q_done.push_back(cyc);
      exp_busy = 1'b0;
      exp_err  = corrupt & CK_EN;
    end
  endtask

  task automatic run_cmd(input logic [1:0] cmd);
    send_word({cmd, 30'h0}, 0);
    if (cmd == 2'b10 && !exp_err) exp_en = 1'b1;
    if (cmd == 2'b11)             exp_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    arst_n    = 1'b0;
    exp_en    = 1'b0;
    exp_busy  = 1'b0;
    exp_ready = 1'b0;
    exp_err   = 1'b0;
    hold_ia   = 64'h0;
    hold_id   = 64'h0;
    hold_da   = 64'h0;
    hold_dd   = 64'h0;
    #1;
    check("rst_wen_ext", 64'(wen_ext), 64'd0);
    check("rst_addr_ext", addr_ext, 64'd0);
    check("rst_wdata_ext_2", wdata_ext_2, 64'd0);
    check("rst_busy_done", {62'h0, busy, done}, 64'd0);
    check("rst_enable", 64'(cpu_enable), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    #1;
    check("ready_after_release", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    exp_ready = 1'b1;
    check("ready_one_clock_later", 64'(in_ready), 64'd1);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  int b2b_last;

  initial begin
    in_valid  = 1'b0;
    in_data   = 32'h0;
    arst_n    = 1'b0;
    exp_en    = 1'b0;
    exp_busy  = 1'b0;
    exp_ready = 1'b0;
    exp_err   = 1'b0;
    hold_ia   = 64'h0;
    hold_id   = 64'h0;
    hold_da   = 64'h0;
    hold_dd   = 64'h0;
    errors    = 0;
    checks    = 0;
    done_cnt  = 0;
    do_reset();

    // IMEM load of three words on consecutive cycles.
    pay[0] = 32'hA000_0000; pay[1] = 32'hA000_0001; pay[2] = 32'hA000_0002;
    load(1'b0, 3, 32'h0000_0010, 3, 0, 1'b0, 14'h0);
    settle();
    check("imem_count", 64'(log_i_addr.size()), 64'd3);
    check("imem_a0", log_i_addr[0], 64'h10);
    check("imem_a2", log_i_addr[2], 64'h18);
    check("imem_d1", log_i_data[1], 64'hA000_0001);

    // DMEM load with stalls; the base 0x107 aligns to 0x100.
    pay[0] = 32'h1111_0000; pay[1] = 32'h2222_0000;
    pay[2] = 32'h3333_0001; pay[3] = 32'h4444_0001;
    load(1'b1, 2, 32'h0000_0107, 2, 2, 1'b0, 14'h0);
    settle();
    check("dmem_count", 64'(log_d_addr.size()), 64'd2);
    check("dmem_a0", log_d_addr[0], 64'h100);
    check("dmem_d0", log_d_data[0], 64'h2222_0000_1111_0000);
    check("dmem_a1", log_d_addr[1], 64'h108);
    check("dmem_d1", log_d_data[1], 64'h4444_0001_3333_0001);

    // Back-to-back loads: the second header follows the last word directly.
    pay[0] = 32'h0000_BEEF;
    load(1'b0, 1, 32'h0000_0200, 1, 0, 1'b0, 14'h0);
    b2b_last = last_cyc;
    load(1'b0, 1, 32'h0000_0300, 1, 0, 1'b0, 14'h0);
    check("b2b_no_bubble", 64'(hdr_cyc - b2b_last), 64'd1);

    // N = 0: done after the base word, no writes.
    settle();
    log_i_addr.delete();
    log_i_data.delete();
    done_cnt = 0;
    load(1'b0, 0, 32'h0000_0040, 0, 0, 1'b0, 14'h0);
    settle();
    check("n0_writes", 64'(log_i_addr.size()), 64'd0);
    check("n0_done", 64'(done_cnt), 64'd1);

    // Reserved bits ignored; 64-bit address carry out of bit 31.
    pay[0] = 32'h5555_5555; pay[1] = 32'h6666_6666;
    load(1'b0, 2, 32'hFFFF_FFFE, 2, 1, 1'b0, 14'h3FFF);
    settle();
    check("wrap_a0", log_i_addr[0], 64'h0000_0000_FFFF_FFFC);
    check("wrap_a1", log_i_addr[1], 64'h0000_0001_0000_0000);

    // Run control.
    run_cmd(2'b10);
    check("start_sets_enable", 64'(cpu_enable), 64'd1);
    pay[0] = 32'h0000_0001;
    load(1'b0, 1, 32'h0000_0080, 1, 0, 1'b0, 14'h0);
    check("load_clears_enable", 64'(en_after_hdr), 64'd0);
    run_cmd(2'b11);
    check("stop_keeps_zero", 64'(cpu_enable), 64'd0);
    run_cmd(2'b10);
    run_cmd(2'b11);
    check("stop_clears_enable", 64'(cpu_enable), 64'd0);

    // Reset after one of three words: nothing more is written.
    settle();
    log_i_addr.delete();
    log_i_data.delete();
    pay[0] = 32'hC000_0000; pay[1] = 32'hC000_0001; pay[2] = 32'hC000_0002;
    load(1'b0, 3, 32'h0000_0500, 1, 0, 1'b0, 14'h0);
    @(negedge clk);
    do_reset();
    settle();
    check("midreset_writes", 64'(log_i_addr.size()), 64'd1);
    pay[0] = 32'hD000_000D;
    load(1'b0, 1, 32'h0000_0600, 1, 0, 1'b0, 14'h0);
    settle();
    check("fresh_load_count", 64'(log_i_addr.size()), 64'd2);
    check("fresh_load_addr", log_i_addr[1], 64'h600);

`ifdef CPU_MEM_LOADER_CHECKSUM_EN
    pay[0] = 32'd1; pay[1] = 32'd2; pay[2] = 32'd3;
    load(1'b0, 3, 32'h0000_0000, 3, 0, 1'b0, 14'h0);
    check("ck_good_err", 64'(err), 64'd0);
    run_cmd(2'b10);
    check("ck_good_start", 64'(cpu_enable), 64'd1);
    load(1'b0, 3, 32'h0000_0000, 3, 0, 1'b1, 14'h0);
    check("ck_bad_err", 64'(err), 64'd1);
    run_cmd(2'b10);
    check("ck_bad_start_ignored", 64'(cpu_enable), 64'd0);
`endif

    settle();
    check("imem_queue_empty", 64'(q_i.size()), 64'd0);
    check("dmem_queue_empty", 64'(q_d.size()), 64'd0);
    check("done_queue_empty", 64'(q_done.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_mem_loader.md
# cpu_mem_loader

Host-side loader that sits directly upstream of `cpu` and drives its external memory ports. It receives a 32-bit command/payload stream over a valid/ready handshake and writes instruction words into instruction memory and 64-bit data words into data memory. It then drives the core's `enable` input on command. It owns the external ports exclusively: the core's internal memory ports are used only while `enable` is high.

## Interface
- `IMEM_WORDS`, default 512: instruction memory depth in 32-bit words. Addresses are byte addresses, stride 4.
- `DMEM_WORDS`, default 1024: data memory depth in 64-bit words. Addresses are byte addresses, stride 8.
- `clk`, input, 1: single clock.
- `arst_n`, input, 1: asynchronous, active-low reset. One clock, async active-low reset, names as above.
- `in_data`, input, 32: stream word.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: loader accepts a word. A transfer occurs when `in_valid` and `in_ready` are both high.
- `addr_ext`, output, 64: instruction memory byte address.
- `wen_ext`, output, 1: instruction memory write strobe.
- `ren_ext`, output, 1: constant 0.
- `wdata_ext`, output, 32: instruction word.
- `addr_ext_2`, output, 64: data memory byte address.
- `wen_ext_2`, output, 1: data memory write strobe.
- `ren_ext_2`, output, 1: constant 0.
- `wdata_ext_2`, output, 64: data word.
- `cpu_enable`, output, 1: connects to `cpu.enable`.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse when a load completes.
- `err`, output, 1: sticky error flag.

## Operation
- Header word fields:
  - `[31:30]` cmd: 00 = LOAD_IMEM, 01 = LOAD_DMEM, 10 = START, 11 = STOP.
  - `[29:16]` reserved, ignored.
  - `[15:0]` N = number of target words.
- Effect of each command:
  - START: sets `cpu_enable`, unless `err` is set, in which case START is ignored.
  - STOP: clears `cpu_enable`.
  - LOAD_*: clears `cpu_enable` in the header-accept cycle, clears `err`, then goes to BASE.
- States: IDLE, BASE, IMEM_DATA, DMEM_LO, DMEM_HI, CHECK (CHECK exists only with the macro).
- IDLE: accepts the header.
- BASE: the next word is the base byte address, zero-extended to 64 bits.
  - Alignment bits are forced to zero: `[1:0]` for IMEM, `[2:0]` for DMEM.
  - If N = 0, return to IDLE and pulse `done`.
- IMEM_DATA: each accepted word is written to the current address. The address then advances by 4. After N words, go to IDLE.
- DMEM_LO then DMEM_HI: the first word is the low half and the second is the high half. Write `{hi,lo}`, advance the address by 8, and repeat N times.
- Address arithmetic is 64-bit. No bounds check is made: writes beyond `IMEM_WORDS`/`DMEM_WORDS` wrap inside the SRAM's own decoding. This wrap is the defined behaviour.
- A remaining-word counter, 16 bits, counts down from N.

## Timing
- `in_ready` is 1 in every state except immediately after reset deassertion: it stays 0 for the first clock after `arst_n` rises. Writes are fully pipelined, so the loader sustains one word per cycle.
- Write latency:
  - `wen_ext`/`wen_ext_2` assert exactly 1 cycle after the accepting edge (IMEM word, or DMEM high half), for exactly one cycle.
  - Address and data are registered and are valid in the same cycle as the strobe.
  - Address and data hold their values when the strobe is low.
- `done` pulses in the same cycle as the final write strobe. For N = 0, it pulses 1 cycle after the base word is accepted.
- `cpu_enable` changes on the clock edge that accepts the header.
- A header arriving back-to-back after the last payload word is accepted with no bubble.
- Reset values:
  - All outputs 0; state IDLE; counters and address 0.
  - Reset asserted mid-load abandons the load. No partial strobe is emitted after `arst_n` falls.
- `in_valid` low stalls the FSM in its current state. No timeout.

## Configuration
- Macro `CPU_MEM_LOADER_CHECKSUM_EN`.
- Defined:
  - After the last payload word (or after the base word when N = 0), CHECK accepts one trailer word.
  - The trailer equals the mod-2^32 sum of all payload words; for DMEM, both halves are included.
  - Mismatch sets `err`. `done` still pulses, one cycle after the trailer is accepted.
- Undefined: there is no CHECK state and no trailer, and `err` is tied to 0.

## Test plan
- Reset: hold `arst_n` = 0 → every output is 0 and `busy` = 0. After release, `in_ready` = 0 for one cycle, then 1.
- IMEM load: stream header `0x0000_0003`, base `0x0000_0010`, words `A0,A1,A2` on consecutive cycles → `wen_ext` pulses at addresses `0x10`, `0x14`, `0x18` with data `A0..A2`, each one cycle after acceptance. `done` coincides with the third pulse.
- DMEM load with stalls: header `0x4000_0002`, base `0x0000_0107` (aligned to `0x100`), halves `L0,H0,L1,H1` with `in_valid` gaps → exactly two `wen_ext_2` pulses: `0x100`/`{H0,L0}` and `0x108`/`{H1,L1}`.
- Run control: START header `0x8000_0000` → `cpu_enable` = 1. A subsequent LOAD_IMEM header → `cpu_enable` = 0 in the same edge. STOP → `cpu_enable` remains 0.
- Reset mid-load: assert `arst_n` after 1 of 3 IMEM words → no further `wen_ext`. The state returns to IDLE and a fresh header is accepted normally.
- With `CPU_MEM_LOADER_CHECKSUM_EN`: IMEM load of `1,2,3`.
  - Trailer `6` → `err` = 0, and a following START sets `cpu_enable`.
  - Trailer `7` → `err` = 1, and START is ignored.
